tipi_reg_master: RTL

TIPI_REG_MASTER -- requirements
Module: tipi_reg_master

---
 rtl/tipi_pkg.sv | 24 ++
 rtl/tipi_sync2.sv | 29 ++
 rtl/tipi_reg_master.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tipi_pkg.sv
`default_nettype none
// ============================================================================
//  tipi_pkg -- register-select codes and FSM states for the TIPI register master
//  Rev 1.0
// ============================================================================
package tipi_pkg;

   localparam logic [1:0] REG_RD = 2'b00;
   localparam logic [1:0] REG_RC = 2'b01;
   localparam logic [1:0] REG_TD = 2'b10;
   localparam logic [1:0] REG_TC = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SLE_HI   = 3'd2,
      ST_SLE_LO   = 3'd3,
      ST_SHIFT_LO = 3'd4,
      ST_SHIFT_HI = 3'd5,
      ST_RESP     = 3'd6
   } state_e;

endpackage
`default_nettype wire

// File: rtl/tipi_sync2.sv
`default_nettype none
// ============================================================================
//  tipi_sync2 -- two-flop synchronizer for the serial data returned by the CPLD
//  Rev 1.0
// ============================================================================
module tipi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/tipi_reg_master.sv
`default_nettype none
// ============================================================================
//  tipi_reg_master -- host-side serial master for the TIPI RD/RC/TD/TC registers
//  Rev 1.0
// ============================================================================
module tipi_reg_master #(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       rpi_sclk,
   output logic       rpi_sle,
   output logic       rpi_sdata_out,
   output logic [1:0] rpi_regsel,
   input  logic       rpi_sdata_in
);

   import tipi_pkg::*;

   localparam logic [7:0] LAST_TICK = 8'(HALF_PERIOD - 1);

   state_e     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] reg_q, reg_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       sclk_q, sclk_d;
   logic       sle_q, sle_d;
   logic       sdo_q, sdo_d;
   logic       sdi_sync;
   logic       phase_end;
   logic       rd_op;

   tipi_sync2 u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rpi_sdata_in),
      .sync_o  (sdi_sync)
   );

   assign phase_end = (timer_q == LAST_TICK);
   assign rd_op     = reg_q[1];

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      if (state_q != ST_IDLE && state_q != ST_RESP) begin
         timer_d = phase_end ? 8'd0 : timer_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_SETUP;
               reg_d   = req_reg;
               wdata_d = req_wdata;
               rdata_d = 8'h00;
               bit_d   = 3'd0;
               timer_d = 8'd0;
            end
         end
         ST_SETUP: begin
            if (phase_end) state_d = rd_op ? ST_SLE_HI : ST_SHIFT_LO;
         end
         ST_SLE_HI: begin
            if (phase_end) state_d = ST_SLE_LO;
         end
         ST_SLE_LO: begin
            if (phase_end) state_d = rd_op ? ST_SHIFT_LO : ST_RESP;
         end
         ST_SHIFT_LO: begin
            // Sample late in the low phase so the synchronized bit has settled.
            if (phase_end) begin
               state_d = ST_SHIFT_HI;
               if (rd_op) rdata_d = {rdata_q[6:0], sdi_sync};
            end
         end
         ST_SHIFT_HI: begin
            if (phase_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = rd_op ? ST_RESP : ST_SLE_HI;
               else               state_d = ST_SHIFT_LO;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Serial pins are registered from the next state so they stay glitch-free.
   always_comb begin
      sclk_d = (state_d == ST_SHIFT_HI);
      sle_d  = (state_d == ST_SLE_HI);
      sdo_d  = 1'b0;
      if (!reg_d[1] && (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI)) begin
         sdo_d = wdata_d[3'd7 - bit_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= 8'd0;
         bit_q   <= 3'd0;
         reg_q   <= 2'b00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         sclk_q  <= 1'b0;
         sle_q   <= 1'b0;
         sdo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         sclk_q  <= sclk_d;
         sle_q   <= sle_d;
         sdo_q   <= sdo_d;
      end
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign rsp_valid     = (state_q == ST_RESP);
   assign rsp_rdata     = rdata_q;
   assign rpi_sclk      = sclk_q;
   assign rpi_sle       = sle_q;
   assign rpi_sdata_out = sdo_q;
   assign rpi_regsel    = reg_q;

endmodule
`default_nettype wire
